reg_file_32: RTL and testbench

REG_FILE_32 -- requirements
Module: reg_file_32

---
 rtl/reg_file_32_pkg.sv | 13 +
 rtl/reg_file_wr_decode.sv | 15 +
 rtl/reg_file_32.sv | 119 +++++++++++
 tb/tb_reg_file_32.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_32_pkg.sv
// Shared constants and FSM state type for the 32-entry register file.
package reg_file_32_pkg;

  localparam int REG_COUNT = 32;
  localparam int SEL_WIDTH = 5;
  localparam logic [SEL_WIDTH-1:0] CNT_LAST = 5'd31;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_wr_decode.sv
// Select-to-one-hot decoder; output is all zeros when en_i is low.
module reg_file_wr_decode
  import reg_file_32_pkg::*;
(
  input  logic                 en_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  output logic [REG_COUNT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/reg_file_32.sv
// 32 x DATA_WIDTH register file, R0 hardwired to zero, two combinational read
// ports and a 31-cycle sequential clear. Define REG_FILE_32_BYPASS_EN for write-to-read bypass.
module reg_file_32
  import reg_file_32_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEnable,
  input  logic [SEL_WIDTH-1:0]  WriteSel,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [SEL_WIDTH-1:0]  ReadSelA,
  input  logic [SEL_WIDTH-1:0]  ReadSelB,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  output logic [DATA_WIDTH-1:0] ReadDataB,
  input  logic                  ClearReq,
  output logic                  Busy,
  output state_t                DbgState
);

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]  wr_onehot;
  logic [REG_COUNT-1:0]  clr_onehot;
  logic                  wr_qual;
  logic                  in_clear;

  assign in_clear = (state_q == CLEAR);
  assign Busy     = in_clear;
  assign DbgState = state_q;
  // A clear starting this cycle takes priority over a simultaneous write.
  assign wr_qual  = WriteEnable && !in_clear && !ClearReq;

  reg_file_wr_decode u_wr_dec (
    .en_i     (wr_qual),
    .sel_i    (WriteSel),
    .onehot_o (wr_onehot)
  );

  reg_file_wr_decode u_clr_dec (
    .en_i     (in_clear),
    .sel_i    (cnt_q),
    .onehot_o (clr_onehot)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter starts at 1 since R0 needs no clearing; exit at 31 so it never wraps in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ClearReq) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (clr_onehot[i] || i == 0) regs_d[i] = '0;
      else if (wr_onehot[i])       regs_d[i] = WriteData;
    end
  end

  generate
    if (CLEAR_ON_RESET != 0) begin : g_regs_rst
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
          for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
        end
      end
    end else begin : g_regs_norst
      always_ff @(posedge Clock) begin
        for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
      end
    end
  endgenerate

  always_comb begin
    ReadDataA = (ReadSelA == '0) ? '0 : regs_q[ReadSelA];
    ReadDataB = (ReadSelB == '0) ? '0 : regs_q[ReadSelB];
`ifdef REG_FILE_32_BYPASS_EN
    if (wr_qual && WriteSel != '0 && ReadSelA == WriteSel) ReadDataA = WriteData;
    if (wr_qual && WriteSel != '0 && ReadSelB == WriteSel) ReadDataB = WriteData;
`endif
  end

endmodule

// File: tb/tb_reg_file_32.sv
// Directed bench for reg_file_32: reset, writes, R0, bypass, clear sequencing, reset mid-clear.
module tb_reg_file_32;
  import reg_file_32_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  rsel_a, rsel_b;
  logic [31:0] rdata_a, rdata_b;
  logic        clr_req;
  logic        busy;
  state_t      dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int busy_cnt;

  reg_file_32 dut (
    .Clock       (clk),
    .Reset       (rst),
    .WriteEnable (we),
    .WriteSel    (wsel),
    .WriteData   (wdata),
    .ReadSelA    (rsel_a),
    .ReadSelB    (rsel_b),
    .ReadDataA   (rdata_a),
    .ReadDataB   (rdata_b),
    .ClearReq    (clr_req),
    .Busy        (busy),
    .DbgState    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wsel = 5'(i); wdata = 32'(i);
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wsel = '0; wdata = '0;
    rsel_a = 5'd5; rsel_b = 5'd31; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_rd_a", rdata_a, 32'd0);
    check("rst_rd_b", rdata_b, 32'd0);

    // release reset and write on the very next edge
    tick();
    rst = 1'b0;
    we = 1'b1; wsel = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    settle();
    check("r5_write", rdata_a, 32'hDEADBEEF);

    we = 1'b1; wsel = 5'd0; wdata = 32'h12345678; rsel_b = 5'd0;
    tick();
    we = 1'b0;
    settle();
    check("r0_discard", rdata_b, 32'd0);

    // same-cycle write/read of R9
    we = 1'b1; wsel = 5'd9; wdata = 32'h55; rsel_a = 5'd9;
    settle();
`ifdef REG_FILE_32_BYPASS_EN
    check("r9_same_cycle", rdata_a, 32'h55);
`else
    check("r9_same_cycle", rdata_a, 32'd0);
`endif
    tick();
    we = 1'b0;
    settle();
    check("r9_next_cycle", rdata_a, 32'h55);

    fill_index();
    rsel_a = 5'd7; rsel_b = 5'd31;
    settle();
    check("fill_r7", rdata_a, 32'd7);
    check("fill_r31", rdata_b, 32'd31);

    // clear and write R3 in the same IDLE cycle: clear wins
    clr_req = 1'b1; we = 1'b1; wsel = 5'd3; wdata = 32'hAA;
    tick();
    clr_req = 1'b0; we = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      we      = (busy_cnt == 2);
      wsel    = 5'd20;
      wdata   = 32'h77;
      clr_req = (busy_cnt == 5);
      rsel_b  = (busy_cnt == 1) ? 5'd3 : 5'd20;
      settle();
      check("clr_r7", rdata_a, (busy_cnt <= 7) ? 32'd7 : 32'd0);
      if (busy_cnt == 1)  check("clr_r3_no_write", rdata_b, 32'd3);
      if (busy_cnt == 10) check("clr_r20_no_write", rdata_b, 32'd20);
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    settle();
    check("busy_len", 32'(busy_cnt), 32'd31);
    check("clr_done_state", 32'(dbg_state), 32'(IDLE));
    for (int i = 0; i < 32; i++) begin
      rsel_a = 5'(i);
      settle();
      check("clr_all_zero", rdata_a, 32'd0);
    end

    // reset in the middle of a clear
    fill_index();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    settle();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    settle();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rsel_a = 5'd31; rsel_b = 5'd15;
    settle();
    check("mid_rst_r31", rdata_a, 32'd0);
    check("mid_rst_r15", rdata_b, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    for (int i = 1; i < 32; i += 6) begin
      rsel_a = 5'(i);
      settle();
      check("post_rst_zero", rdata_a, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
